// File: rtl/enigma_pkg.sv
// Shared Enigma datapath types: letter indices and the rotor step-state encoding.
// Letters are 5-bit indices A=0 .. Z=25.
package enigma_pkg;

   localparam int LETTER_W = 5;
   localparam int ALPHABET = 26;

   typedef logic [LETTER_W-1:0] letter_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STEPPING,
      S_DONE
   } step_state_t;

   function automatic letter_t next_letter(letter_t l);
      return (l >= letter_t'(ALPHABET - 1)) ? '0 : l + letter_t'(1);
   endfunction

endpackage

// File: rtl/rotor_counter.sv
// Single rotor position: mod-26 letter register with clamped load and advance.
// at_notch_o flags the turnover position for the rotor to its left.
module rotor_counter
   import enigma_pkg::*;
#(
   parameter int NOTCH = 0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic [4:0] load_val_i,
   input  logic       en_i,
   output logic [4:0] q_o,
   output logic       at_notch_o
);

   letter_t pos_q;
   letter_t pos_d;

   always_comb begin
      pos_d = pos_q;
      if (load_i) begin
         pos_d = (load_val_i >= letter_t'(ALPHABET)) ? '0 : load_val_i;
      end else if (en_i) begin
         pos_d = next_letter(pos_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign q_o        = pos_q;
   assign at_notch_o = (pos_q == letter_t'(NOTCH));

endmodule

// File: rtl/rotor_stepper.sv
// Three-rotor position generator: key-edge FSM driving right/middle/left
// rotors with notch turnover and the middle-rotor double step.
module rotor_stepper
   import enigma_pkg::*;
#(
   parameter int NOTCH_R = 16,
   parameter int NOTCH_M = 4,
   parameter int NOTCH_L = 21
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STEP,
   input  logic        LOAD,
   input  logic [14:0] LOAD_POS,
   output logic [4:0]  POS_L,
   output logic [4:0]  POS_M,
   output logic [4:0]  POS_R,
   output logic        BUSY,
   output logic        DONE,
   output logic        LOAD_ERR,
   output logic        CARRY_L
);

   step_state_t state_q;
   logic        step_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic        edge_w;
   logic        adv_w;
   logic        err_d;
   logic        r_notch;
   logic        m_notch;
   logic        l_notch;

   assign edge_w = STEP & ~step_q;
   assign adv_w  = (state_q == S_STEPPING) & ~LOAD;

   assign err_d = LOAD &
      ((LOAD_POS[14:10] >= letter_t'(ALPHABET)) |
       (LOAD_POS[9:5]   >= letter_t'(ALPHABET)) |
       (LOAD_POS[4:0]   >= letter_t'(ALPHABET)));

   rotor_counter #(.NOTCH(NOTCH_R)) u_rot_r (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (LOAD),
      .load_val_i (LOAD_POS[4:0]),
      .en_i       (adv_w),
      .q_o        (POS_R),
      .at_notch_o (r_notch)
   );

   // Middle steps on right turnover, or on its own notch (double step).
   rotor_counter #(.NOTCH(NOTCH_M)) u_rot_m (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (LOAD),
      .load_val_i (LOAD_POS[9:5]),
      .en_i       (adv_w & (r_notch | m_notch)),
      .q_o        (POS_M),
      .at_notch_o (m_notch)
   );

   rotor_counter #(.NOTCH(NOTCH_L)) u_rot_l (
      .clk_i      (CLK),
      .rst_i      (RST),
      .load_i     (LOAD),
      .load_val_i (LOAD_POS[14:10]),
      .en_i       (adv_w & m_notch),
      .q_o        (POS_L),
      .at_notch_o (l_notch)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         step_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         step_q <= STEP;
         err_q  <= err_d;
         if (LOAD) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  done_q <= 1'b0;
                  if (edge_w) begin
                     state_q <= S_STEPPING;
                     busy_q  <= 1'b1;
                  end else begin
                     busy_q  <= 1'b0;
                  end
               end
               S_STEPPING: begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b1;
               end
               default: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign LOAD_ERR = err_q;
   assign CARRY_L  = l_notch;

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_rotor_stepper;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        STEP = 1'b0;
   logic        LOAD = 1'b0;
   logic [14:0] LOAD_POS = '0;
   logic [4:0]  POS_L, POS_M, POS_R;
   logic        BUSY, DONE, LOAD_ERR, CARRY_L;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model state
   int m_l, m_m, m_r;
   int m_phase;      // cycles into a step: 0 idle, 1 turning, 2 settled
   int m_prev;
   int m_done, m_err;

   always #5 CLK = ~CLK;

   rotor_stepper dut (
      .CLK      (CLK),
      .RST      (RST),
      .STEP     (STEP),
      .LOAD     (LOAD),
      .LOAD_POS (LOAD_POS),
      .POS_L    (POS_L),
      .POS_M    (POS_M),
      .POS_R    (POS_R),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .LOAD_ERR (LOAD_ERR),
      .CARRY_L  (CARRY_L)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int mk(input int l, input int m, input int r);
      return l * 1024 + m * 32 + r;
   endfunction

   function automatic int pos();
      return mk(int'(POS_L), int'(POS_M), int'(POS_R));
   endfunction

   task automatic model_edge();
      int fl, fm, fr, prev_old;
      bit tm_r, tm_m;
      if (RST) begin
         m_l = 0; m_m = 0; m_r = 0;
         m_phase = 0; m_prev = 1; m_done = 0; m_err = 0;
         return;
      end
      prev_old = m_prev;
      m_prev   = int'(STEP);
      m_done   = 0;
      m_err    = 0;
      if (LOAD) begin
         fl = int'(LOAD_POS[14:10]);
         fm = int'(LOAD_POS[9:5]);
         fr = int'(LOAD_POS[4:0]);
         m_err = (fl > 25 || fm > 25 || fr > 25) ? 1 : 0;
         m_l = (fl > 25) ? 0 : fl;
         m_m = (fm > 25) ? 0 : fm;
         m_r = (fr > 25) ? 0 : fr;
         m_phase = 0;
      end else if (m_phase == 0) begin
         if (STEP && prev_old == 0) m_phase = 1;
      end else if (m_phase == 1) begin
         tm_r = (m_r == 16);
         tm_m = (m_m == 4);
         m_r = (m_r + 1) % 26;
         if (tm_r || tm_m) m_m = (m_m + 1) % 26;
         if (tm_m) m_l = (m_l + 1) % 26;
         m_phase = 2;
         m_done  = 1;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      check("pos", pos(), mk(m_l, m_m, m_r));
      check("busy", int'(BUSY), (m_phase != 0) ? 1 : 0);
      check("done", int'(DONE), m_done);
      check("load_err", int'(LOAD_ERR), m_err);
      check("carry_l", int'(CARRY_L), (m_l == 21) ? 1 : 0);
   endtask

   task automatic do_load(input int l, input int m, input int r);
      LOAD = 1'b1;
      LOAD_POS = {5'(l), 5'(m), 5'(r)};
      tick();
      LOAD = 1'b0;
   endtask

   // Edge at N; BUSY in N+1, DONE and new positions in N+2, idle in N+3.
   task automatic do_step();
      STEP = 1'b1;
      tick();
      check("step_busy", int'(BUSY), 1);
      check("step_nodone", int'(DONE), 0);
      STEP = 1'b0;
      tick();
      check("step_done", int'(DONE), 1);
      tick();
      check("step_done_once", int'(DONE), 0);
      check("step_idle", int'(BUSY), 0);
   endtask

   initial begin
      int dcount;
      m_l = 0; m_m = 0; m_r = 0;
      m_phase = 0; m_prev = 1; m_done = 0; m_err = 0;

      // Key held through reset release must not step
      STEP = 1'b1;
      RST  = 1'b1;
      tick();
      tick();
      check("reset_pos", pos(), 0);
      check("reset_busy", int'(BUSY), 0);
      RST = 1'b0;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         dcount += int'(DONE);
      end
      check("held_through_reset", pos(), 0);
      check("held_through_reset_done", dcount, 0);
      STEP = 1'b0;
      tick();

      do_step();
      check("basic_step", pos(), mk(0, 0, 1));

      do_load(0, 0, 16);
      do_step();
      check("right_turnover", pos(), mk(0, 1, 17));
      do_load(0, 0, 25);
      do_step();
      check("right_wrap", pos(), mk(0, 0, 0));

      do_load(0, 3, 16);
      do_step();
      check("dbl_1", pos(), mk(0, 4, 17));
      do_step();
      check("dbl_2", pos(), mk(1, 5, 18));
      do_step();
      check("dbl_3", pos(), mk(1, 5, 19));

      // Held key for 20 cycles: one step only
      do_load(0, 0, 0);
      STEP = 1'b1;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         dcount += int'(DONE);
      end
      STEP = 1'b0;
      tick();
      check("held_done_count", dcount, 1);
      check("held_pos", pos(), mk(0, 0, 1));

      // Load in the STEPPING cycle aborts the step
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      do_load(2, 2, 2);
      check("ld_step_pos", pos(), mk(2, 2, 2));
      check("ld_step_busy", int'(BUSY), 0);
      check("ld_step_done", int'(DONE), 0);
      tick();
      check("ld_step_done2", int'(DONE), 0);
      check("ld_step_pos2", pos(), mk(2, 2, 2));

      // Simultaneous LOAD and STEP edge in IDLE
      STEP = 1'b1;
      do_load(5, 6, 7);
      tick();
      tick();
      check("ld_edge_pos", pos(), mk(5, 6, 7));
      check("ld_edge_busy", int'(BUSY), 0);
      STEP = 1'b0;
      tick();

      do_load(27, 3, 31);
      check("oor_pos", pos(), mk(0, 3, 0));
      check("oor_err", int'(LOAD_ERR), 1);
      tick();
      check("oor_err_once", int'(LOAD_ERR), 0);

      // Reset in the DONE cycle
      do_load(4, 4, 4);
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      tick();
      check("rst_done_pre", int'(DONE), 1);
      RST = 1'b1;
      tick();
      check("rst_done_pos", pos(), 0);
      check("rst_done_done", int'(DONE), 0);
      check("rst_done_busy", int'(BUSY), 0);
      RST = 1'b0;
      tick();

      do_load(21, 0, 0);
      check("carry_l_set", int'(CARRY_L), 1);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 2) == 0) STEP = ~STEP;
         LOAD = ($urandom_range(0, 15) == 0);
         LOAD_POS = 15'($urandom);
         if ($urandom_range(0, 3) == 0) LOAD_POS = {5'($urandom_range(0, 25)), 5'($urandom_range(2, 5)), 5'($urandom_range(14, 17))};
         RST = ($urandom_range(0, 99) == 0);
         tick();
      end
      RST = 1'b0;
      LOAD = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Three-rotor position generator for the Enigma datapath. It holds the left, middle and right rotor positions as 5-bit letter indices (A=0 … Z=25) and advances them once per key press with historical notch turnover, including the middle-rotor double step. It feeds rotor offsets to the substitution path, which consumes these letter indices.

## Interface

**Parameters**
- NOTCH_R, default 16 (Q): right-rotor turnover position.
- NOTCH_M, default 4 (E): middle-rotor turnover position.
- NOTCH_L, default 21 (V): left-rotor turnover position. Reported only; there is no fourth rotor.

**Ports**
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- STEP  in  1  key-press level; a step is triggered by its rising edge.
- LOAD  in  1  load rotor start positions this cycle.
- LOAD_POS  in  15  {L, M, R}, 5 bits each.
- POS_L, POS_M, POS_R  out  5 each  current rotor positions (registered).
- BUSY  out  1  high while a step is in flight (state ≠ IDLE).
- DONE  out  1  one-cycle pulse when the new positions are valid.
- LOAD_ERR  out  1  one-cycle pulse when a loaded field was ≥26.
- CARRY_L  out  1  combinational: POS_L == NOTCH_L.

## Operation

- **States:** IDLE, STEPPING, DONE.
  - IDLE → STEPPING on a detected STEP edge.
  - STEPPING → DONE always.
  - DONE → IDLE always.
- **Edge detect:** register step_q <= STEP. An edge is STEP & ~step_q, and it is sampled only in IDLE. Edges seen in STEPPING or DONE are discarded, not queued.
- **Update on leaving STEPPING** (all conditions are evaluated on the old values):
  - R always advances.
  - M advances if (R == NOTCH_R) or (M == NOTCH_M). The second term is the double step.
  - L advances if M == NOTCH_M.
- **Advance:** mod 26, so 25 → 0. Values are always held in range 0–25.
- **LOAD:**
  - Has priority over any step.
  - Legal in any state. It forces the state to IDLE and suppresses that cycle's update.
  - Each field ≥26 is stored as 0.
  - LOAD_ERR pulses the next cycle if any field was out of range.
  - DONE is not asserted for a load.
- **Reset:** RST has priority over LOAD and STEP.
- **Simultaneous LOAD and STEP edge in IDLE:** the load wins and the edge is consumed, so no step occurs.

## Timing

- **Reset values:**
  - POS_L, POS_M, POS_R = 0; state = IDLE.
  - BUSY = 0, DONE = 0, LOAD_ERR = 0.
  - step_q = 1, so a key held through reset does not step.
- **Step latency:** edge sampled at cycle N.
  - BUSY = 1 in N+1.
  - New positions and DONE = 1 in N+2.
  - Back in IDLE in N+3. The next edge can be accepted in N+3.
- **Load latency:** LOAD at N → positions visible in N+1; LOAD_ERR, if any, in N+1.
- **Reset mid-step:** RST in STEPPING or DONE clears everything the next cycle. No DONE is emitted.
- CARRY_L is the only combinational output.

## Structure

- **Shared package enigma_pkg:**
  - LETTER_W = 5
  - ALPHABET = 26
  - typedef letter_t (logic [4:0])
  - step-state enum {IDLE, STEPPING, DONE}
  - function next_letter(letter_t)
- **Sub-module rotor_counter**, instantiated three times:
  - 5-bit mod-26 register with load (clamp ≥26 to 0), an enable to advance, and an at_notch output.
  - NOTCH is a parameter.
- **Top level:** FSM, edge detect and the stepping logic.

## Test plan

1. **Reset and basic step:** reset, then a STEP pulse. Required:
   - positions 0,0,1 two cycles after the edge;
   - DONE high for exactly one cycle;
   - BUSY high the cycle before.
2. **Right turnover:** load {0,0,16}, then step. Required:
   - {0,1,17}.
   - Load {0,0,25}, step: {0,0,0}, with no carry and M unchanged.
3. **Double step** (NOTCH_M = 4): load {0,3,16}, then three steps. Required sequence:
   - {0,4,17}
   - {1,5,18}
   - {1,5,19}
4. **Held key:** STEP high for 20 cycles. Required:
   - exactly one step and one DONE;
   - STEP held high through reset release produces no step.
5. **Load during step:** LOAD {2,2,2} in the STEPPING cycle. Required:
   - positions {2,2,2} the next cycle;
   - state IDLE;
   - no DONE.
   - Also: LOAD with STEP edge simultaneously in IDLE loads without stepping.
6. **Out-of-range load:** LOAD {27,3,31}. Required:
   - {0,3,0};
   - LOAD_ERR pulses once.
   - RST asserted during the DONE cycle forces all outputs to 0 with DONE low the next cycle.
